// File: rtl/int_sequencer_pkg.sv
// Shared types and constants for the interrupt entry/exit sequencer.
package int_sequencer_pkg;

  localparam int DATA_W           = 8;
  localparam int CCR_Z            = 0;
  localparam int CCR_N            = 1;
  localparam int CCR_C            = 2;
  localparam int CCR_V            = 3;
  localparam int FLAG_W           = CCR_V + 1;
  localparam int DRAIN_CYCLES_DEF = 3;
  localparam logic [DATA_W-1:0] VEC_ADDR = 8'h01;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    PUSH     = 3'd2,
    VEC      = 3'd3,
    REDIRECT = 3'd4,
    IN_ISR   = 3'd5
  } state_t;

endpackage

// File: rtl/int_sequencer_if.sv
// Signal bundle between the interrupt sequencer and the core (fetch, hazard unit, memory arbiter).
interface int_sequencer_if;
  import int_sequencer_pkg::*;

  logic              int_in;
  logic              flush_busy;
  logic [DATA_W-1:0] pc_next;
  logic [DATA_W-1:0] sp_in;
  logic [FLAG_W-1:0] ccr_in;
  logic              rti_retire;
  logic              mem_gnt;
  logic [DATA_W-1:0] mem_rdata;
  logic              fetch_hold;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              sp_dec;
  logic              pc_load;
  logic [DATA_W-1:0] pc_val;
  logic              ccr_restore;
  logic [FLAG_W-1:0] ccr_saved;
  logic              in_isr;

  modport master (
    input  int_in, flush_busy, pc_next, sp_in, ccr_in, rti_retire, mem_gnt, mem_rdata,
    output fetch_hold, mem_req, mem_we, mem_addr, mem_wdata, sp_dec, pc_load, pc_val,
           ccr_restore, ccr_saved, in_isr
  );

  modport slave (
    output int_in, flush_busy, pc_next, sp_in, ccr_in, rti_retire, mem_gnt, mem_rdata,
    input  fetch_hold, mem_req, mem_we, mem_addr, mem_wdata, sp_dec, pc_load, pc_val,
           ccr_restore, ccr_saved, in_isr
  );

endinterface

// File: rtl/int_sequencer_edge_latch.sv
// Rising-edge detector on the interrupt pin with a one-deep pending flag.
module int_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic i_int_in,
  input  logic i_clr,
  output logic o_pending
);

  logic r_int_q;
  logic r_pending;
  logic w_rise;

  assign w_rise = i_int_in & ~r_int_q;

  // A rise in the clearing cycle wins so that request is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_q   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_int_q <= i_int_in;
      if (w_rise)
        r_pending <= 1'b1;
      else if (i_clr)
        r_pending <= 1'b0;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/int_sequencer.sv
// Interrupt entry/exit controller: drain, push return PC, fetch vector, redirect, restore flags on RTI.
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  int_sequencer_if.master io_seq
);

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic [DATA_W-1:0] r_ret_pc;
  logic [DATA_W-1:0] r_vector;
  logic [FLAG_W-1:0] r_ccr_saved;
  logic              r_hold;
  logic              r_mem_req;
  logic              r_mem_we;
  logic              r_pc_load;
  logic              r_in_isr;

  logic              w_pending;
  logic              w_accept;
  logic              w_clr;
  logic [DATA_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  int_edge_latch u_edge (
    .clk       (clk),
    .rst       (rst),
    .i_int_in  (io_seq.int_in),
    .i_clr     (w_clr),
    .o_pending (w_pending)
  );

  assign w_accept = (r_state == IDLE) & w_pending & ~io_seq.flush_busy;
  assign w_clr    = (r_state == REDIRECT);

  // Registered outputs are set on the transition into the state that owns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ret_pc    <= '0;
      r_vector    <= '0;
      r_ccr_saved <= '0;
      r_hold      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_pc_load   <= 1'b0;
      r_in_isr    <= 1'b0;
    end else begin
      r_pc_load <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_ret_pc <= io_seq.pc_next;
          r_cnt    <= 8'(DRAIN_CYCLES - 1);
          r_hold   <= 1'b1;
          r_state  <= DRAIN;
        end
        DRAIN: if (r_cnt == 8'd0) begin
          r_mem_req <= 1'b1;
          r_mem_we  <= 1'b1;
          r_state   <= PUSH;
        end else begin
          r_cnt <= r_cnt - 8'd1;
        end
        PUSH: if (io_seq.mem_gnt) begin
          r_ccr_saved <= io_seq.ccr_in;
          r_mem_we    <= 1'b0;
          r_state     <= VEC;
        end
        VEC: if (io_seq.mem_gnt) begin
          r_vector  <= io_seq.mem_rdata;
          r_mem_req <= 1'b0;
          r_pc_load <= 1'b1;
          r_state   <= REDIRECT;
        end
        REDIRECT: begin
          r_hold   <= 1'b0;
          r_in_isr <= 1'b1;
          r_state  <= IN_ISR;
        end
        IN_ISR: if (io_seq.rti_retire) begin
          r_in_isr <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The push address follows the live SP so the controller never keeps its own copy.
  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (r_state == PUSH) begin
      w_mem_addr  = io_seq.sp_in;
      w_mem_wdata = r_ret_pc;
    end else if (r_state == VEC) begin
      w_mem_addr = VEC_ADDR;
    end
  end

  assign io_seq.fetch_hold  = w_accept | r_hold;
  assign io_seq.mem_req     = r_mem_req;
  assign io_seq.mem_we      = r_mem_we;
  assign io_seq.mem_addr    = w_mem_addr;
  assign io_seq.mem_wdata   = w_mem_wdata;
  assign io_seq.sp_dec      = (r_state == PUSH) & io_seq.mem_gnt;
  assign io_seq.pc_load     = r_pc_load;
  assign io_seq.pc_val      = r_vector;
  assign io_seq.ccr_restore = (r_state == IN_ISR) & io_seq.rti_retire;
  assign io_seq.ccr_saved   = r_ccr_saved;
  assign io_seq.in_isr      = r_in_isr;

endmodule

// File: tb/tb_int_sequencer.sv
// Testbench for int_sequencer: directed vector table, hand-written corner sequences, random vs model.
module tb_int_sequencer;
  import int_sequencer_pkg::*;

  localparam int D = DRAIN_CYCLES_DEF;

  typedef struct packed {
    logic       intIn;
    logic       flush;
    logic       gnt;
    logic       rti;
    logic [7:0] pcNext;
    logic [7:0] sp;
    logic [7:0] rdata;
    logic [3:0] ccr;
  } stim_t;

  typedef struct packed {
    logic       fetchHold;
    logic       memReq;
    logic       memWe;
    logic [7:0] memAddr;
    logic [7:0] memWdata;
    logic       spDec;
    logic       pcLoad;
    logic [7:0] pcVal;
    logic       inIsr;
    logic       ccrRestore;
    logic [3:0] ccrSaved;
  } outs_t;

  typedef struct packed {
    stim_t s;
    outs_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passes = 0;
  int pcLoads = 0;

  int_sequencer_if bus();

  int_sequencer #(.DRAIN_CYCLES(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_seq (bus)
  );

  always #5 clk = ~clk;

  // Reference model: an entry is a numbered walk of steps (1..D drain, D+1 push, D+2 vector
  // read, D+3 redirect) that only stalls on a missing grant; ISR residency is a separate flag.
  bit         mPrevInt, mPending, mInIsr;
  int         mStep;
  logic [7:0] mRetPc, mVector;
  logic [3:0] mCcr;

  function automatic outs_t modelOutputs(input stim_t s);
    outs_t o;
    bit    accept;
    o = '0;
    accept      = (mStep == 0) && !mInIsr && mPending && !s.flush;
    o.fetchHold = accept || (mStep >= 1 && mStep <= D + 3);
    o.memReq    = (mStep == D + 1) || (mStep == D + 2);
    o.memWe     = (mStep == D + 1);
    o.memAddr   = (mStep == D + 1) ? s.sp : ((mStep == D + 2) ? 8'h01 : 8'h00);
    o.memWdata  = (mStep == D + 1) ? mRetPc : 8'h00;
    o.spDec     = (mStep == D + 1) && s.gnt;
    o.pcLoad    = (mStep == D + 3);
    o.pcVal     = mVector;
    o.inIsr     = mInIsr;
    o.ccrRestore = mInIsr && s.rti;
    o.ccrSaved  = mCcr;
    return o;
  endfunction

  task automatic modelClock(input stim_t s, input logic r);
    bit rise, accept;
    if (r) begin
      mPrevInt = 0; mPending = 0; mInIsr = 0; mStep = 0;
      mRetPc = '0; mVector = '0; mCcr = '0;
    end else begin
      rise   = s.intIn && !mPrevInt;
      accept = (mStep == 0) && !mInIsr && mPending && !s.flush;
      mPrevInt = s.intIn;
      if (rise) mPending = 1;
      else if (mStep == D + 3) mPending = 0;
      if (accept) begin
        mRetPc = s.pcNext;
        mStep  = 1;
      end else if (mStep >= 1 && mStep <= D) begin
        mStep = mStep + 1;
      end else if (mStep == D + 1) begin
        if (s.gnt) begin mCcr = s.ccr; mStep = mStep + 1; end
      end else if (mStep == D + 2) begin
        if (s.gnt) begin mVector = s.rdata; mStep = mStep + 1; end
      end else if (mStep == D + 3) begin
        mStep  = 0;
        mInIsr = 1;
      end else if (mInIsr && s.rti) begin
        mInIsr = 0;
      end
    end
  endtask

  function automatic outs_t sampleDut();
    outs_t a;
    a.fetchHold  = bus.fetch_hold;
    a.memReq     = bus.mem_req;
    a.memWe      = bus.mem_we;
    a.memAddr    = bus.mem_addr;
    a.memWdata   = bus.mem_wdata;
    a.spDec      = bus.sp_dec;
    a.pcLoad     = bus.pc_load;
    a.pcVal      = bus.pc_val;
    a.inIsr      = bus.in_isr;
    a.ccrRestore = bus.ccr_restore;
    a.ccrSaved   = bus.ccr_saved;
    return a;
  endfunction

  task automatic applyStimulus(input stim_t s, input logic r);
    @(negedge clk);
    bus.int_in     = s.intIn;
    bus.flush_busy = s.flush;
    bus.mem_gnt    = s.gnt;
    bus.rti_retire = s.rti;
    bus.pc_next    = s.pcNext;
    bus.sp_in      = s.sp;
    bus.mem_rdata  = s.rdata;
    bus.ccr_in     = s.ccr;
    rst            = r;
    #1;
    if (bus.pc_load) pcLoads++;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = sampleDut();
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic stepModel(input string name, input stim_t s, input logic r);
    applyStimulus(s, r);
    checkOutput(name, modelOutputs(s));
    @(posedge clk);
    modelClock(s, r);
  endtask

  function automatic stim_t st(input logic i, f, g, r, input logic [3:0] c);
    stim_t s;
    s.intIn = i; s.flush = f; s.gnt = g; s.rti = r;
    s.pcNext = 8'h05; s.sp = 8'hFF; s.rdata = 8'hB0; s.ccr = c;
    return s;
  endfunction

  function automatic outs_t ex(input logic h, q, w, input logic [7:0] a, d, input logic sd, pl,
                               input logic [7:0] pv, input logic ii, cr, input logic [3:0] cs);
    outs_t o;
    o.fetchHold = h; o.memReq = q; o.memWe = w; o.memAddr = a; o.memWdata = d;
    o.spDec = sd; o.pcLoad = pl; o.pcVal = pv; o.inIsr = ii; o.ccrRestore = cr; o.ccrSaved = cs;
    return o;
  endfunction

  initial begin
    vec_t  tbl[11];
    stim_t s;
    int    base;
    logic  curInt;

    // Entry with zero-wait grants, then an ISR that changes flags and returns.
    tbl[0]  = '{st(1, 0, 1, 0, 4'b0100), ex(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 4'h0)};
    tbl[1]  = '{st(0, 0, 1, 0, 4'b0100), ex(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 4'h0)};
    tbl[2]  = '{st(0, 0, 1, 0, 4'b0100), ex(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 4'h0)};
    tbl[3]  = '{st(0, 0, 1, 0, 4'b0100), ex(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 4'h0)};
    tbl[4]  = '{st(0, 0, 1, 0, 4'b0100), ex(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 4'h0)};
    tbl[5]  = '{st(0, 0, 1, 0, 4'b0100), ex(1, 1, 1, 8'hFF, 8'h05, 1, 0, 8'h00, 0, 0, 4'h0)};
    tbl[6]  = '{st(0, 0, 1, 0, 4'b0100), ex(1, 1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 0, 0, 4'b0100)};
    tbl[7]  = '{st(0, 0, 1, 0, 4'b0100), ex(1, 0, 0, 8'h00, 8'h00, 0, 1, 8'hB0, 0, 0, 4'b0100)};
    tbl[8]  = '{st(0, 0, 1, 0, 4'b1011), ex(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'hB0, 1, 0, 4'b0100)};
    tbl[9]  = '{st(0, 0, 1, 1, 4'b1011), ex(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'hB0, 1, 1, 4'b0100)};
    tbl[10] = '{st(0, 0, 1, 0, 4'b1011), ex(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'hB0, 0, 0, 4'b0100)};

    $display("[TB] reset");
    applyStimulus(st(0, 0, 1, 0, 4'h0), 1'b1);
    @(posedge clk);
    modelClock(st(0, 0, 1, 0, 4'h0), 1'b1);
    applyStimulus(st(0, 0, 1, 0, 4'h0), 1'b1);
    checkOutput("reset_state", '0);
    @(posedge clk);
    modelClock(st(0, 0, 1, 0, 4'h0), 1'b1);

    $display("[TB] vector table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].s, 1'b0);
      checkOutput($sformatf("table_%0d", i), tbl[i].e);
      @(posedge clk);
      modelClock(tbl[i].s, 1'b0);
    end

    $display("[TB] flush_busy blocks entry");
    for (int i = 0; i < 16; i++) begin
      s = st(1, i < 4, 1, 0, 4'h9);
      s.pcNext = 8'(8'h40 + i);
      stepModel($sformatf("flush_%0d", i), s, 1'b0);
    end
    checkCount("flush_ret_pc", int'(mRetPc), 8'h44);
    stepModel("flush_rti", st(1, 0, 1, 1, 4'h0), 1'b0);

    $display("[TB] held pin and nested edge");
    base = pcLoads;
    for (int i = 0; i < 2; i++)  stepModel("hold_low", st(0, 0, 1, 0, 4'h2), 1'b0);
    for (int i = 0; i < 10; i++) stepModel("hold_high", st(1, 0, 1, 0, 4'h2), 1'b0);
    for (int i = 0; i < 3; i++)  stepModel("hold_tail", st(0, 0, 1, 0, 4'h2), 1'b0);
    checkCount("held_one_entry", pcLoads - base, 1);
    stepModel("nest_rise", st(1, 0, 1, 0, 4'h2), 1'b0);
    for (int i = 0; i < 4; i++) stepModel("nest_wait", st(0, 0, 1, 0, 4'h2), 1'b0);
    checkCount("nest_not_taken", pcLoads - base, 1);
    stepModel("nest_rti", st(0, 0, 1, 1, 4'h2), 1'b0);
    for (int i = 0; i < 10; i++) stepModel("nest_reentry", st(0, 0, 1, 0, 4'h2), 1'b0);
    checkCount("nest_reentered", pcLoads - base, 2);
    stepModel("nest_rti2", st(0, 0, 1, 1, 4'h2), 1'b0);

    $display("[TB] grant stalls");
    base = pcLoads;
    for (int c = 0; c < 16; c++) begin
      s = st(c == 0, 0, !((c >= 5 && c <= 7) || (c >= 9 && c <= 11)), 0, 4'h6);
      s.rdata = 8'hB0;
      stepModel($sformatf("stall_%0d", c), s, 1'b0);
    end
    checkCount("stall_one_load", pcLoads - base, 1);
    stepModel("stall_rti", st(0, 0, 1, 1, 4'h0), 1'b0);

    $display("[TB] reset during vector read");
    base = pcLoads;
    for (int c = 0; c < 7; c++)
      stepModel($sformatf("rstvec_%0d", c), st(c == 0, 0, c != 6, 0, 4'h3), c == 6);
    applyStimulus(st(0, 0, 1, 0, 4'h3), 1'b0);
    checkOutput("rstvec_outputs_zero", '0);
    @(posedge clk);
    modelClock(st(0, 0, 1, 0, 4'h3), 1'b0);
    for (int c = 0; c < 10; c++) stepModel("rstvec_after", st(0, 0, 1, 0, 4'h3), 1'b0);
    checkCount("rstvec_no_load", pcLoads - base, 0);

    $display("[TB] random traffic");
    curInt = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) curInt = ~curInt;
      s.intIn  = curInt;
      s.flush  = ($urandom_range(0, 3) == 0);
      s.gnt    = ($urandom_range(0, 9) < 7);
      s.rti    = ($urandom_range(0, 5) == 0);
      s.pcNext = 8'($urandom);
      s.sp     = 8'($urandom);
      s.rdata  = 8'($urandom);
      s.ccr    = 4'($urandom);
      stepModel($sformatf("rand_%0d", c), s, $urandom_range(0, 255) == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
